// File: rtl/rsa_pkg.sv
// Shared constants and state types for the RSA decryption datapath.
// Used by both the input deserializer and the output serializer.
package rsa_pkg;

    localparam int RSA_WIDTH  = 512;
    localparam int RSA_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } shift_out_state_t;

endpackage

// File: rtl/rsa_shift_out.sv
// Output serializer: captures one result word and streams it MSB byte first
// over an 8-bit valid/ready interface, then pulses done for one cycle.
module rsa_shift_out
    import rsa_pkg::*;
#(
    parameter int WIDTH  = RSA_WIDTH,
    parameter int BYTE_W = RSA_BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  dataIn,
    input  logic              ready,
    output logic [BYTE_W-1:0] dataOut,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int CW     = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    shift_out_state_t state;
    logic [WIDTH-1:0] shiftReg;
    logic [CW-1:0]    count;

    // Handshake: a byte moves on every rising edge where valid && ready.
    // valid depends only on state, so dataOut is stable across ready=0 cycles.
    assign dataOut   = shiftReg[WIDTH-1 -: BYTE_W];
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shiftReg <= '0;
            count    <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shiftReg <= dataIn;
                        count    <= '0;
                        state    <= SEND;
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    // load is ignored here, including on the final transfer edge
                    if (ready) begin
                        shiftReg <= shiftReg << BYTE_W;
                        count    <= count + 1'b1;
                        if (count == LAST) begin
                            state <= DONE;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_shift_out.sv
// Bench for rsa_shift_out: reference byte queue filled at load time, drained by a monitor.
module tb_rsa_shift_out;
    import rsa_pkg::*;

    localparam int W  = RSA_WIDTH;
    localparam int BW = RSA_BYTE_W;
    localparam int NB = W / BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  dataIn = '0;
    logic          ready = 1'b0;
    logic [BW-1:0] dataOut;
    logic          valid, busy, done;
    logic [1:0]    state_dbg;

    // each entry: {last_byte_of_word, byte}
    logic [BW:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int ready_mode = 0;  // 0: high, 1: toggle, 2: random, 3: low
    logic done_exp = 1'b0;
    logic prev_done = 1'b0;

    rsa_shift_out dut (
        .clk(clk), .rst(rst), .load(load), .dataIn(dataIn), .ready(ready),
        .dataOut(dataOut), .valid(valid), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: word split into bytes, most significant first
    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < NB; i++)
            exp_q.push_back({(i == NB - 1), w[W-1-BW*i -: BW]});
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: ready = 1'b1;
            1: ready = ~ready;
            2: ready = ($urandom_range(0, 99) < 60);
            default: ready = 1'b0;
        endcase
    end

    // monitor
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            done_exp = 1'b0;
            prev_done = 1'b0;
        end else begin
            check("done_pulse", {63'd0, done}, {63'd0, done_exp});
            done_exp = 1'b0;
            if (prev_done) check("busy_after_done", {63'd0, busy}, 64'd0);
            prev_done = done;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {63'd0, valid}, 64'd0);
                end else begin
                    check("data_out", {56'd0, dataOut}, {56'd0, exp_q[0][BW-1:0]});
                    if (ready) begin
                        done_exp = exp_q[0][BW];
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && !done_exp) ok = 1'b1;
        end
        if (!ok) check("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    // returns #1 after the accepting edge
    task automatic send_word(input logic [W-1:0] w);
        wait_idle();
        dataIn = w;
        load = 1'b1;
        push_word(w);
        @(posedge clk);
        #1;
        load = 1'b0;
        check("first_valid", {63'd0, valid}, 64'd1);
        check("first_busy", {63'd0, busy}, 64'd1);
        check("first_byte", {56'd0, dataOut}, {56'd0, w[W-1 -: BW]});
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    logic [W-1:0] seq_w, wa, wb;

    initial begin
        for (int i = 0; i < NB; i++) seq_w[W-1-BW*i -: BW] = BW'(i);

        // reset values
        #2;
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_data", {56'd0, dataOut}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ready held high: exact timing of final transfer, done, idle
        ready_mode = 0;
        send_word(seq_w);
        repeat (NB) @(posedge clk);
        #1;
        check("done_at_k65", {63'd0, done}, 64'd1);
        check("valid_at_k65", {63'd0, valid}, 64'd0);
        @(posedge clk);
        #1;
        check("idle_at_k66", {62'd0, busy, done}, 64'd0);

        // ready toggling
        ready_mode = 1;
        send_word(seq_w);

        // load held high: second word captured only after return to idle
        wait_idle();
        ready_mode = 2;
        wa = rand_word();
        wb = rand_word();
        dataIn = wa;
        load = 1'b1;
        push_word(wa);
        @(posedge clk);
        #1;
        dataIn = wb;
        push_word(wb);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 2000 && !seen; i++) begin
                @(negedge clk);
                if (!busy) seen = 1'b1;
            end
            if (!seen) check("hold_load_timeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1 load = 1'b0;
        check("hold_load_second_busy", {63'd0, busy}, 64'd1);
        check("hold_load_second_byte", {56'd0, dataOut}, {56'd0, wb[W-1 -: BW]});

        // reset after 10 transfers, then all-FF word
        ready_mode = 0;
        send_word(rand_word());
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, valid}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_data", {56'd0, dataOut}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        send_word({W{1'b1}});

        // loopback pattern
        ready_mode = 2;
        send_word({(W/16){16'hA55A}});

        // long stall right after load
        wait_idle();
        ready_mode = 3;
        wa = rand_word();
        send_word(wa);
        repeat (100) @(posedge clk);
        #1;
        check("stall_valid", {63'd0, valid}, 64'd1);
        check("stall_byte", {56'd0, dataOut}, {56'd0, wa[W-1 -: BW]});
        check("stall_done", {63'd0, done}, 64'd0);
        ready_mode = 2;

        // random words with random and full-rate ready
        for (int n = 0; n < 6; n++) begin
            ready_mode = (n % 2 == 0) ? 2 : 0;
            send_word(rand_word());
        end

        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
